mem_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port `memory` block between up to `NUM_REQ` requesters, e.g. the host loader, the systolic-array weight/image fetcher and the result writer. It accepts one transaction per two cycles. It registers the winning command onto the memory port, range-checks addresses, and returns read data with a one-cycle valid pulse. It sits directly in front of `memory` and is the only block that drives it.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/rr_picker.sv | 36 +++
 rtl/mem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the round-robin memory arbiter.
package mem_arb_pkg;

  localparam int unsigned MAX_REQ = 4;
  localparam int unsigned PTR_W   = $clog2(MAX_REQ);
  localparam int unsigned CMD_AW  = 32;
  localparam int unsigned CMD_DW  = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef struct packed {
    logic              we;
    logic              be;
    logic [CMD_AW-1:0] addr;
    logic [CMD_DW-1:0] wdata;
  } mem_cmd_t;

  // Pointer value that follows a grant to requester win_idx.
  function automatic logic [PTR_W-1:0] next_ptr(input int unsigned win_idx,
                                                input int unsigned num_req);
    return (win_idx + 32'd1 >= num_req) ? '0 : PTR_W'(win_idx + 32'd1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win,
  output logic               any
);

  localparam int unsigned IW = PTR_W + 1;

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = IW'(ptr) + IW'(off);
      if (idx >= IW'(NUM_REQ)) idx = idx - IW'(NUM_REQ);
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (idx == IW'(i))) begin
          win[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter driving the single-port memory, one transaction per two cycles.
// Optional statistics counters are enabled with MEM_ARB_STATS_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned MEM_SIZE      = 1024,
  parameter int unsigned NUM_REQ       = 3
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQ-1:0]                     req,
  input  logic [NUM_REQ-1:0]                     req_we,
  input  logic [NUM_REQ-1:0]                     req_be,
  input  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]                     gnt,
  output logic [NUM_REQ-1:0]                     rvalid,
  output logic [NUM_REQ-1:0]                     err,
  output logic [DATA_WIDTH-1:0]                  rdata,
  output logic                                   busy,
  output logic [ADDRESS_WIDTH-1:0]               mem_address,
  output logic [DATA_WIDTH-1:0]                  mem_write_data,
  output logic                                   mem_we,
  output logic                                   mem_re,
  output logic                                   mem_be,
  input  logic [DATA_WIDTH-1:0]                  mem_read_data
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][31:0]               grant_count,
  output logic [31:0]                            conflict_count
`endif
);

  localparam logic [ADDRESS_WIDTH-1:0] WORD_LAST = ADDRESS_WIDTH'(MEM_SIZE * 4 - 4);
  localparam logic [ADDRESS_WIDTH-1:0] BYTE_LAST = ADDRESS_WIDTH'(MEM_SIZE * 4 - 1);

  state_t                   state_q, state_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d, nxt_ptr;
  logic [NUM_REQ-1:0]       gnt_q, gnt_d, rvalid_q, rvalid_d, err_q, err_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d, mem_wdata_q, mem_wdata_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d, sel_addr;
  logic                     busy_q, busy_d;
  logic                     mem_we_q, mem_we_d, mem_re_q, mem_re_d, mem_be_q, mem_be_d;
  logic [NUM_REQ-1:0]       win;
  logic                     any;
  logic                     addr_ok;
  mem_cmd_t                 cmd_sel;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req (req),
    .ptr (ptr_q),
    .win (win),
    .any (any)
  );

  // Winner's command and the pointer value that follows it.
  always_comb begin
    cmd_sel = '0;
    nxt_ptr = ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win[i]) begin
        cmd_sel.we    = req_we[i];
        cmd_sel.be    = req_be[i];
        cmd_sel.addr  = CMD_AW'(req_addr[i]);
        cmd_sel.wdata = CMD_DW'(req_wdata[i]);
        nxt_ptr       = next_ptr(i, NUM_REQ);
      end
    end
  end

  assign sel_addr = ADDRESS_WIDTH'(cmd_sel.addr);

  always_comb begin
    if (cmd_sel.be) addr_ok = (sel_addr <= BYTE_LAST);
    else            addr_ok = (sel_addr[1:0] == 2'b00) && (sel_addr <= WORD_LAST);
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = '0;
    rvalid_d    = '0;
    err_d       = '0;
    rdata_d     = rdata_q;
    busy_d      = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_be_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d     = ACCESS;
          ptr_d       = nxt_ptr;
          gnt_d       = win;
          busy_d      = 1'b1;
          mem_addr_d  = sel_addr;
          mem_wdata_d = DATA_WIDTH'(cmd_sel.wdata);
          mem_we_d    = cmd_sel.we & addr_ok;
          mem_re_d    = ~cmd_sel.we & addr_ok;
          mem_be_d    = cmd_sel.be & addr_ok;
        end
      end
      ACCESS: begin
        // gnt_q still holds the owner of the access in flight.
        state_d = IDLE;
        if (mem_re_q) begin
          rvalid_d = gnt_q;
          rdata_d  = mem_read_data;
        end else if (!mem_we_q) begin
          err_d = gnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_be_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign gnt            = gnt_q;
  assign rvalid         = rvalid_q;
  assign err            = err_q;
  assign rdata          = rdata_q;
  assign busy           = busy_q;
  assign mem_address    = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_we         = mem_we_q;
  assign mem_re         = mem_re_q;
  assign mem_be         = mem_be_q;

`ifdef MEM_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] grant_cnt_q, grant_cnt_d;
  logic [31:0]              conflict_cnt_q, conflict_cnt_d;

  // Saturating grant and contention counters, updated only on IDLE cycles.
  always_comb begin
    grant_cnt_d    = grant_cnt_q;
    conflict_cnt_d = conflict_cnt_q;
    if (state_q == IDLE) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (win[i] && (grant_cnt_q[i] != '1)) grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
      end
      if (($countones(req) >= 2) && (conflict_cnt_q != '1)) conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      grant_cnt_q    <= grant_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign grant_count    = grant_cnt_q;
  assign conflict_count = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model, directed cases, random traffic.
module tb_mem_arbiter;

  localparam int unsigned N = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N-1:0]          req, req_we, req_be;
  logic [N-1:0][31:0]    req_addr, req_wdata;
  logic [N-1:0]          gnt, rvalid, err;
  logic [31:0]           rdata;
  logic                  busy;
  logic [31:0]           mem_address, mem_write_data, mem_read_data;
  logic                  mem_we, mem_re, mem_be;
`ifdef MEM_ARB_STATS_EN
  logic [N-1:0][31:0]    grant_count;
  logic [31:0]           conflict_count;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .MEM_SIZE(1024), .NUM_REQ(N)
  ) dut (
    .clk(clk), .reset(reset),
    .req(req), .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .rvalid(rvalid), .err(err), .rdata(rdata), .busy(busy),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_we(mem_we), .mem_re(mem_re), .mem_be(mem_be),
    .mem_read_data(mem_read_data)
`ifdef MEM_ARB_STATS_EN
    ,
    .grant_count(grant_count), .conflict_count(conflict_count)
`endif
  );

  // Stand-in memory: async read, byte mode returns the zero-extended byte.
  logic [31:0] smem [1024];
  logic [31:0] sword;
  always_comb begin
    sword = smem[mem_address[11:2]];
    mem_read_data = mem_be ? {24'h0, sword[{mem_address[1:0], 3'b000} +: 8]} : sword;
  end
  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_be) smem[mem_address[11:2]][{mem_address[1:0], 3'b000} +: 8] <= mem_write_data[7:0];
      else        smem[mem_address[11:2]] <= mem_write_data;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-addressed memory plus a pending transaction.
  logic [7:0]   mm [4096];
  int           m_ptr;
  bit           m_access;
  int           p_who;
  logic         p_we, p_be, p_ok;
  logic [31:0]  p_addr, p_wdata;
  logic [N-1:0] e_gnt, e_rvalid, e_err, n_gnt, n_rvalid, n_err;
  logic         e_busy, e_we, e_re, e_be, n_busy, n_we, n_re, n_be;
  logic [31:0]  e_addr, e_wdata, e_rdata, n_addr, n_wdata, n_rdata;
  logic [11:0]  ai;
  int unsigned  m_gcount [N];
  int unsigned  m_conflict;

  function automatic logic legal(input logic be, input logic [31:0] a);
    if (be) return a <= 32'd4095;
    return (a % 4 == 0) && (a <= 32'd4092);
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_gnt", 32'(gnt), 0);       chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_err", 32'(err), 0);       chk("rst_busy", 32'(busy), 0);
      chk("rst_mem_we", 32'(mem_we), 0); chk("rst_mem_re", 32'(mem_re), 0);
      chk("rst_mem_be", 32'(mem_be), 0); chk("rst_rdata", rdata, 0);
      chk("rst_mem_addr", mem_address, 0);
      m_ptr = 0; m_access = 0; m_conflict = 0;
      for (int i = 0; i < N; i++) m_gcount[i] = 0;
      {e_gnt, e_rvalid, e_err, e_busy, e_we, e_re, e_be} = '0;
    end else begin
      chk("gnt", 32'(gnt), 32'(e_gnt));          chk("rvalid", 32'(rvalid), 32'(e_rvalid));
      chk("err", 32'(err), 32'(e_err));          chk("busy", 32'(busy), 32'(e_busy));
      chk("mem_we", 32'(mem_we), 32'(e_we));     chk("mem_re", 32'(mem_re), 32'(e_re));
      if (e_we || e_re) begin
        chk("mem_be", 32'(mem_be), 32'(e_be));
        chk("mem_address", mem_address, e_addr);
      end
      if (e_we) chk("mem_write_data", mem_write_data, e_wdata);
      if (|e_rvalid) chk("rdata", rdata, e_rdata);
      {n_gnt, n_rvalid, n_err, n_busy, n_we, n_re, n_be} = '0;
      n_addr = e_addr; n_wdata = e_wdata; n_rdata = e_rdata;
      if (m_access) begin
        m_access = 0;
        ai = p_addr[11:0];
        if (!p_ok) n_err[p_who] = 1'b1;
        else if (p_we) begin
          if (p_be) mm[ai] = p_wdata[7:0];
          else for (int k = 0; k < 4; k++) mm[ai + 12'(k)] = p_wdata[8*k +: 8];
        end else begin
          n_rvalid[p_who] = 1'b1;
          n_rdata = p_be ? {24'h0, mm[ai]} : {mm[ai + 12'd3], mm[ai + 12'd2], mm[ai + 12'd1], mm[ai]};
        end
      end else begin
        if ($countones(req) >= 2) m_conflict++;
        if (req != '0) begin
          p_who = -1;
          for (int off = 0; off < N; off++)
            if (p_who < 0 && req[(m_ptr + off) % N]) p_who = (m_ptr + off) % N;
          m_ptr   = (p_who + 1) % N;
          p_we    = req_we[p_who];  p_be = req_be[p_who];
          p_addr  = req_addr[p_who]; p_wdata = req_wdata[p_who];
          p_ok    = legal(p_be, p_addr);
          m_access = 1;
          m_gcount[p_who]++;
          n_gnt[p_who] = 1'b1;
          n_busy = 1'b1;
          n_we = p_we && p_ok; n_re = !p_we && p_ok; n_be = p_be && p_ok;
          n_addr = p_addr; n_wdata = p_wdata;
        end
      end
      e_gnt = n_gnt; e_rvalid = n_rvalid; e_err = n_err; e_busy = n_busy;
      e_we = n_we; e_re = n_re; e_be = n_be; e_addr = n_addr; e_wdata = n_wdata; e_rdata = n_rdata;
    end
  end

  bit re_watch = 0, re_seen = 0;
  always @(negedge clk) if (re_watch && mem_re) re_seen = 1;

  // Per-run observations from run_set.
  int          grant_order[$];
  int          first_gnt_cyc;
  int          got_rv [N], got_err [N], rv_cyc [N];
  logic [31:0] got_rdata [N];

  task automatic set_cmd(input int i, input logic we, input logic be, input logic [31:0] a, input logic [31:0] d);
    req_we[i] = we; req_be[i] = be; req_addr[i] = a; req_wdata[i] = d;
  endtask

  // Hold the masked requesters until each has been granted per_req times.
  task automatic run_set(input logic [N-1:0] mask, input int per_req);
    int rem [N];
    int cyc, tail;
    bit all_done;
    grant_order.delete();
    first_gnt_cyc = -1;
    for (int i = 0; i < N; i++) begin
      rem[i] = mask[i] ? per_req : 0; got_rv[i] = 0; got_err[i] = 0; rv_cyc[i] = -1;
    end
    req = mask;
    cyc = 0; tail = 0;
    while (tail < 2 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      for (int i = 0; i < N; i++) begin
        if (rvalid[i]) begin got_rv[i]++; got_rdata[i] = rdata; rv_cyc[i] = cyc; end
        if (err[i]) got_err[i]++;
        if (gnt[i]) begin
          grant_order.push_back(i);
          if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
          if (rem[i] > 0) rem[i]--;
          if (rem[i] == 0) req[i] = 1'b0;
        end
      end
      all_done = 1;
      for (int i = 0; i < N; i++) if (rem[i] != 0) all_done = 0;
      if (all_done) tail++;
    end
    chk("run_set_timeout", 32'(cyc < 100), 1);
    req = '0;
  endtask

  task automatic reset_idle();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic new_cmd(input int i);
    int r;
    logic we, be;
    logic [31:0] a;
    r = $urandom % 10; we = 1'($urandom % 2); be = 1'($urandom % 2);
    if (r < 7)       a = be ? $urandom % 64 : ($urandom % 16) * 4;
    else if (r == 7) a = be ? 32'd4095 : 32'd4092;
    else if (r == 8) begin be = 1'b0; a = ($urandom % 16) * 4 + 1 + $urandom % 3; end
    else             a = ($urandom % 2) ? 32'd4096 + $urandom % 64 : 32'hFFFF_FFFC;
    set_cmd(i, we, be, a, $urandom);
    req[i] = 1'b1;
  endtask

  int exp_ord [6] = '{0, 1, 2, 0, 1, 2};
  int cnt;

  initial begin
    reset = 1'b1;
    req = '0; req_we = '0; req_be = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 1024; i++) smem[i] = '0;
    for (int i = 0; i < 4096; i++) mm[i] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Word write then word read of 0x18.
    set_cmd(0, 1'b1, 1'b0, 32'h18, 32'hB6A84325);
    run_set(3'b001, 1);
    chk("t1_gnt_latency", 32'(first_gnt_cyc), 1);
    chk("t1_grant_id", 32'(grant_order[0]), 0);
    set_cmd(0, 1'b0, 1'b0, 32'h18, 32'h0);
    run_set(3'b001, 1);
    chk("t1_rvalid_count", 32'(got_rv[0]), 1);
    chk("t1_rvalid_latency", 32'(rv_cyc[0]), 2);
    chk("t1_rdata", got_rdata[0], 32'hB6A84325);

    // Byte write into lane 1, then word read.
    set_cmd(0, 1'b1, 1'b1, 32'h19, 32'h74);
    run_set(3'b001, 1);
    chk("t2_write_rvalid", 32'(got_rv[0]), 0);
    set_cmd(0, 1'b0, 1'b0, 32'h18, 32'h0);
    run_set(3'b001, 1);
    chk("t2_rdata", got_rdata[0], 32'hB6A87425);

    // Three requesters held high: fair rotation from ptr 0.
    reset_idle();
    for (int i = 0; i < N; i++) set_cmd(i, 1'b0, 1'b0, 32'h18, 32'h0);
    run_set(3'b111, 2);
    chk("t3_grant_total", 32'(grant_order.size()), 6);
    for (int k = 0; k < 6; k++)
      if (k < grant_order.size()) chk($sformatf("t3_order_%0d", k), 32'(grant_order[k]), 32'(exp_ord[k]));
`ifdef MEM_ARB_STATS_EN
    chk("t3_conflict_nonzero", 32'(conflict_count > 0), 1);
`endif

    // Rejected accesses: misaligned word and out-of-range byte.
    re_watch = 1; re_seen = 0;
    set_cmd(0, 1'b0, 1'b0, 32'h1A, 32'h0);
    run_set(3'b001, 1);
    chk("t4_err_misaligned", 32'(got_err[0]), 1);
    chk("t4_no_rvalid", 32'(got_rv[0]), 0);
    set_cmd(0, 1'b0, 1'b1, 32'h1000, 32'h0);
    run_set(3'b001, 1);
    chk("t4_err_byte_oob", 32'(got_err[0]), 1);
    re_watch = 0;
    chk("t4_mem_re_never", 32'(re_seen), 0);

    // Top-of-memory boundaries.
    set_cmd(0, 1'b1, 1'b0, 32'hFFC, 32'hCAFEF00D);
    run_set(3'b001, 1);
    chk("bnd_word_write_ok", 32'(got_err[0]), 0);
    set_cmd(0, 1'b0, 1'b1, 32'hFFF, 32'h0);
    run_set(3'b001, 1);
    chk("bnd_byte_read_last", got_rdata[0], 32'h0000_00CA);
    set_cmd(0, 1'b0, 1'b0, 32'h1000, 32'h0);
    run_set(3'b001, 1);
    chk("bnd_word_oob", 32'(got_err[0]), 1);

    // Reset during the ACCESS of an overwriting write.
    set_cmd(0, 1'b1, 1'b0, 32'h20, 32'h11111111);
    run_set(3'b001, 1);
    set_cmd(1, 1'b1, 1'b0, 32'h20, 32'hFFFFFFFF);
    req[1] = 1'b1;
    cnt = 0;
    do begin @(posedge clk); #1; cnt++; end while (!gnt[1] && cnt < 20);
    chk("t5_gnt1", 32'(gnt[1]), 1);
    #2 reset = 1'b1; req = '0;
    #1 chk("t5_abort_mem_we", 32'(mem_we), 0);
    chk("t5_abort_busy", 32'(busy), 0);
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < N; i++) set_cmd(i, 1'b0, 1'b0, 32'h20, 32'h0);
    run_set(3'b111, 1);
    chk("t5_first_after_reset", 32'(grant_order[0]), 0);
    for (int i = 0; i < N; i++) chk($sformatf("t5_rdata_%0d", i), got_rdata[i], 32'h11111111);

    // Random traffic, checked cycle by cycle against the model.
    repeat (3000) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (req[i] && gnt[i]) begin
          if ($urandom % 3 == 0) new_cmd(i);
          else req[i] = 1'b0;
        end else if (!req[i] && ($urandom % 4 == 0)) begin
          new_cmd(i);
        end
      end
    end
    req = '0;
    repeat (4) @(posedge clk);
    #1;
`ifdef MEM_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk($sformatf("stat_grant_%0d", i), grant_count[i], m_gcount[i]);
    chk("stat_conflict", conflict_count, m_conflict);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
